// File: rtl/arb_burst_sched_pkg.sv
// ---------------------------------------------------------------------------
// arb_burst_sched_pkg
//   Shared types for the two-source burst scheduler: the arbiter state
//   encoding and the source identifiers used for data_source / last_src.
// ---------------------------------------------------------------------------
package arb_burst_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT0  = 2'd1,
      GRANT1  = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam logic SRC_SLV0 = 1'b0;
   localparam logic SRC_SLV1 = 1'b1;

endpackage

// File: rtl/arb_burst_sched_if.sv
// ---------------------------------------------------------------------------
// arb_burst_sched_if
//   Bus bundle between the two beat sources, the downstream master/FIFO and
//   the scheduler.
//   slave  modport : scheduler side (sources and downstream status in,
//                    readies / forwarded beat / status out)
//   master modport : environment side (drives sources and downstream status)
// ---------------------------------------------------------------------------
interface arb_burst_sched_if #(
   parameter int DW    = 32,
   parameter int CNT_W = 16
);
   logic [1:0]       slv0_mode;
   logic             slv0_data_valid;
   logic [7:0]       slv0_proc_valid;
   logic [DW-1:0]    slv0_data;
   logic [1:0]       slv1_mode;
   logic             slv1_data_valid;
   logic [7:0]       slv1_proc_valid;
   logic [DW-1:0]    slv1_data;
   logic             mstr0_cmplt;
   logic             fifo_full;
   logic             slv0_ready;
   logic             slv1_ready;
   logic [1:0]       slvx_mode;
   logic             slvx_data_valid;
   logic [7:0]       slvx_proc_val;
   logic [DW-1:0]    slvx_data;
   logic             data_source;
   logic             burst_timeout;
   logic [CNT_W-1:0] burst_beats;

   modport slave (
      input  slv0_mode, slv0_data_valid, slv0_proc_valid, slv0_data,
      input  slv1_mode, slv1_data_valid, slv1_proc_valid, slv1_data,
      input  mstr0_cmplt, fifo_full,
      output slv0_ready, slv1_ready,
      output slvx_mode, slvx_data_valid, slvx_proc_val, slvx_data,
      output data_source, burst_timeout, burst_beats
   );

   modport master (
      output slv0_mode, slv0_data_valid, slv0_proc_valid, slv0_data,
      output slv1_mode, slv1_data_valid, slv1_proc_valid, slv1_data,
      output mstr0_cmplt, fifo_full,
      input  slv0_ready, slv1_ready,
      input  slvx_mode, slvx_data_valid, slvx_proc_val, slvx_data,
      input  data_source, burst_timeout, burst_beats
   );
endinterface

// File: rtl/arb_burst_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// arb_burst_sched_rr_pick
//   Combinational 2-way round-robin pick.
//   i_req[1:0]  : request per source (bit n = source n)
//   i_last_src  : source that owned the previous burst
//   o_gnt_src   : chosen source
//   o_gnt_vld   : at least one request present
// ---------------------------------------------------------------------------
module arb_burst_sched_rr_pick
   import arb_burst_sched_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_src,
   output logic       o_gnt_src,
   output logic       o_gnt_vld
);

   always_comb begin
      o_gnt_vld = |i_req;
      o_gnt_src = SRC_SLV0;
      // Under contention the source that did not own the last burst wins.
      if (i_req == 2'b11) begin
         o_gnt_src = ~i_last_src;
      end else if (i_req[1]) begin
         o_gnt_src = SRC_SLV1;
      end
   end

endmodule

// File: rtl/arb_burst_sched.sv
// ---------------------------------------------------------------------------
// arb_burst_sched
//   Two-source burst scheduler. Grants slv0 or slv1 the datapath for a whole
//   burst (grant until mstr0_cmplt or idle watchdog), round-robin between
//   the sources, stalls on fifo_full, and forwards accepted beats one cycle
//   later on the slvx_* bus tagged with data_source.
// Ports
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : arb_burst_sched_if.slave
//          in : slvN_mode/data_valid/proc_valid/data, mstr0_cmplt, fifo_full
//          out: slvN_ready (comb), slvx_mode/data_valid/proc_val/data,
//               data_source, burst_timeout (comb pulse), burst_beats
// ---------------------------------------------------------------------------
module arb_burst_sched
   import arb_burst_sched_pkg::*;
#(
   parameter int DW       = 32,
   parameter int IDLE_MAX = 64,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   arb_burst_sched_if.slave    bus
);

   localparam int            IW        = $clog2(IDLE_MAX);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_MAX - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic             r_last_src;
   logic [IW-1:0]    r_idle_cnt;
   logic [1:0]       r_mode;
   logic             r_src;
   logic [CNT_W-1:0] r_beats;
   logic             r_vld_p1;
   logic [7:0]       r_proc_p1;
   logic [DW-1:0]    r_data_p1;

   logic             w_gnt_src;
   logic             w_gnt_vld;
   logic             w_rdy0;
   logic             w_rdy1;
   logic             w_granted;
   logic             w_xfer;
   logic             w_idle_cyc;
   logic             w_timeout;
   logic [7:0]       w_src_proc;
   logic [DW-1:0]    w_src_data;

   arb_burst_sched_rr_pick u_rr_pick (
      .i_req      ({bus.slv1_data_valid, bus.slv0_data_valid}),
      .i_last_src (r_last_src),
      .o_gnt_src  (w_gnt_src),
      .o_gnt_vld  (w_gnt_vld)
   );

   always_comb begin
      w_granted  = (r_state == GRANT0) || (r_state == GRANT1);
      w_rdy0     = (r_state == GRANT0) && !bus.fifo_full;
      w_rdy1     = (r_state == GRANT1) && !bus.fifo_full;
      w_xfer     = (w_rdy0 && bus.slv0_data_valid) || (w_rdy1 && bus.slv1_data_valid);
      // fifo_full cycles are neither idle nor active: the count holds.
      w_idle_cyc = w_granted && !bus.fifo_full && !w_xfer;
      w_timeout  = w_idle_cyc && (r_idle_cnt == IDLE_LAST);
      w_src_data = (r_state == GRANT1) ? bus.slv1_data       : bus.slv0_data;
      w_src_proc = (r_state == GRANT1) ? bus.slv1_proc_valid : bus.slv0_proc_valid;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_gnt_vld) w_state_nxt = (w_gnt_src == SRC_SLV1) ? GRANT1 : GRANT0;
         GRANT0,
         GRANT1:  if (bus.mstr0_cmplt || w_timeout) w_state_nxt = RELEASE;
         RELEASE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_src <= SRC_SLV1;
         r_idle_cnt <= '0;
         r_mode     <= '0;
         r_src      <= SRC_SLV0;
         r_beats    <= '0;
      end else begin
         if (r_state == IDLE && w_gnt_vld) begin
            r_mode  <= (w_gnt_src == SRC_SLV1) ? bus.slv1_mode : bus.slv0_mode;
            r_src   <= w_gnt_src;
            r_beats <= '0;
         end else if (w_xfer) begin
            r_beats <= sat_inc(r_beats);
         end

         if (r_state == RELEASE || w_xfer || w_timeout) r_idle_cnt <= '0;
         else if (w_idle_cyc)                           r_idle_cnt <= r_idle_cnt + IW'(1);

         if (r_state == RELEASE) r_last_src <= r_src;
      end
   end

   // ---- stage p1: registered beat forward ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1  <= 1'b0;
         r_proc_p1 <= '0;
         r_data_p1 <= '0;
      end else begin
         r_vld_p1 <= w_xfer;
         if (w_xfer) begin
            r_proc_p1 <= w_src_proc;
            r_data_p1 <= w_src_data;
         end
      end
   end

   assign bus.slv0_ready      = w_rdy0;
   assign bus.slv1_ready      = w_rdy1;
   assign bus.slvx_mode       = r_mode;
   assign bus.slvx_data_valid = r_vld_p1;
   assign bus.slvx_proc_val   = r_proc_p1;
   assign bus.slvx_data       = r_data_p1;
   assign bus.data_source     = r_src;
   assign bus.burst_timeout   = w_timeout;
   assign bus.burst_beats     = r_beats;

endmodule

// File: tb/tb_arb_burst_sched.sv
module tb_arb_burst_sched;
   import arb_burst_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   arb_burst_sched_if #(.DW(32), .CNT_W(16)) bus ();

   arb_burst_sched #(.DW(32), .IDLE_MAX(8), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) tick;
      n_total++; if (bus.slvx_data_valid !== 1'b0) $display("FAIL rst_vld: got %0h want 0", bus.slvx_data_valid); else n_pass++;
      n_total++; if (bus.slvx_data !== 32'h0) $display("FAIL rst_data: got %0h want 0", bus.slvx_data); else n_pass++;
      n_total++; if (bus.slvx_mode !== 2'b00) $display("FAIL rst_mode: got %0h want 0", bus.slvx_mode); else n_pass++;
      n_total++; if (bus.data_source !== 1'b0) $display("FAIL rst_src: got %0h want 0", bus.data_source); else n_pass++;
      n_total++; if (bus.burst_beats !== 16'h0) $display("FAIL rst_beats: got %0h want 0", bus.burst_beats); else n_pass++;
      n_total++; if ({bus.slv0_ready, bus.slv1_ready, bus.burst_timeout} !== 3'b000)
         $display("FAIL rst_ctrl: got %b want 000", {bus.slv0_ready, bus.slv1_ready, bus.burst_timeout}); else n_pass++;
      rst = 1'b0;
      tick;
   endtask

   task automatic test_contention;
      bus.slv0_data_valid = 1'b1; bus.slv0_data = 32'h20; bus.slv0_mode = 2'd1;
      bus.slv1_data_valid = 1'b1; bus.slv1_data = 32'h30; bus.slv1_mode = 2'd3;
      tick;
      n_total++; if (bus.data_source !== 1'b0) $display("FAIL cont_first_src: got %0h want 0", bus.data_source); else n_pass++;
      n_total++; if ({bus.slv0_ready, bus.slv1_ready} !== 2'b10) $display("FAIL cont_first_rdy: got %b want 10", {bus.slv0_ready, bus.slv1_ready}); else n_pass++;
      n_total++; if (bus.slvx_mode !== 2'd1) $display("FAIL cont_first_mode: got %0h want 1", bus.slvx_mode); else n_pass++;
      bus.mstr0_cmplt = 1'b1;
      tick;
      bus.mstr0_cmplt = 1'b0;
      n_total++; if (bus.slvx_data !== 32'h20 || bus.slvx_data_valid !== 1'b1) $display("FAIL cont_beat0: got %0h/%0h want 20/1", bus.slvx_data, bus.slvx_data_valid); else n_pass++;
      tick;
      tick;
      n_total++; if (bus.data_source !== 1'b1) $display("FAIL cont_second_src: got %0h want 1", bus.data_source); else n_pass++;
      n_total++; if ({bus.slv0_ready, bus.slv1_ready} !== 2'b01) $display("FAIL cont_second_rdy: got %b want 01", {bus.slv0_ready, bus.slv1_ready}); else n_pass++;
      n_total++; if (bus.slvx_mode !== 2'd3) $display("FAIL cont_second_mode: got %0h want 3", bus.slvx_mode); else n_pass++;
      bus.mstr0_cmplt = 1'b1;
      tick;
      bus.mstr0_cmplt = 1'b0;
      bus.slv0_data_valid = 1'b0; bus.slv1_data_valid = 1'b0;
      n_total++; if (bus.slvx_data !== 32'h30) $display("FAIL cont_beat1: got %0h want 30", bus.slvx_data); else n_pass++;
      tick;
   endtask

   task automatic test_single;
      bus.slv0_data_valid = 1'b1; bus.slv0_data = 32'h11; bus.slv0_mode = 2'd2;
      #1;
      n_total++; if (bus.slv0_ready !== 1'b0) $display("FAIL single_idle_rdy: got %0h want 0", bus.slv0_ready); else n_pass++;
      tick;
      n_total++; if (bus.data_source !== 1'b0 || bus.slvx_mode !== 2'd2) $display("FAIL single_grant: got src %0h mode %0h want 0/2", bus.data_source, bus.slvx_mode); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         bus.slv0_data = 32'h11 + 32'(i);
         bus.slv0_proc_valid = 8'hA0 + 8'(i);
         bus.mstr0_cmplt = (i == 3);
         #1;
         n_total++; if (bus.slv0_ready !== 1'b1) $display("FAIL single_rdy%0d: got %0h want 1", i, bus.slv0_ready); else n_pass++;
         tick;
         n_total++; if (bus.slvx_data_valid !== 1'b1 || bus.slvx_data !== 32'h11 + 32'(i) || bus.slvx_proc_val !== 8'hA0 + 8'(i))
            $display("FAIL single_beat%0d: got %0h/%0h/%0h want 1/%0h/%0h", i, bus.slvx_data_valid, bus.slvx_data, bus.slvx_proc_val, 32'h11 + 32'(i), 8'hA0 + 8'(i)); else n_pass++;
         n_total++; if (bus.burst_beats !== 16'(i + 1)) $display("FAIL single_cnt%0d: got %0d want %0d", i, bus.burst_beats, i + 1); else n_pass++;
      end
      bus.mstr0_cmplt = 1'b0; bus.slv0_data_valid = 1'b0;
      n_total++; if (bus.slv0_ready !== 1'b0) $display("FAIL single_release_rdy: got %0h want 0", bus.slv0_ready); else n_pass++;
      tick;
      n_total++; if (bus.slvx_data_valid !== 1'b0 || bus.slvx_data !== 32'h14) $display("FAIL single_hold: got %0h/%0h want 0/14", bus.slvx_data_valid, bus.slvx_data); else n_pass++;
      n_total++; if (bus.burst_beats !== 16'd4 || bus.data_source !== 1'b0) $display("FAIL single_final: got %0d/%0h want 4/0", bus.burst_beats, bus.data_source); else n_pass++;
   endtask

   task automatic test_backpressure;
      int k;
      logic ff;
      k = 0;
      bus.slv0_data_valid = 1'b1; bus.slv0_data = 32'h40;
      tick;
      for (int c = 0; c < 7; c++) begin
         ff = (c >= 2 && c <= 4);
         bus.fifo_full   = ff;
         bus.slv0_data   = 32'h40 + 32'(k);
         bus.mstr0_cmplt = (c == 6);
         #1;
         n_total++; if (bus.slv0_ready !== !ff) $display("FAIL bp_rdy%0d: got %0h want %0h", c, bus.slv0_ready, !ff); else n_pass++;
         n_total++; if (bus.burst_timeout !== 1'b0) $display("FAIL bp_to%0d: got %0h want 0", c, bus.burst_timeout); else n_pass++;
         tick;
         n_total++; if (bus.slvx_data_valid !== !ff) $display("FAIL bp_vld%0d: got %0h want %0h", c, bus.slvx_data_valid, !ff); else n_pass++;
         if (!ff) begin
            n_total++; if (bus.slvx_data !== 32'h40 + 32'(k)) $display("FAIL bp_data%0d: got %0h want %0h", c, bus.slvx_data, 32'h40 + 32'(k)); else n_pass++;
            k++;
         end
      end
      bus.fifo_full = 1'b0; bus.mstr0_cmplt = 1'b0; bus.slv0_data_valid = 1'b0;
      n_total++; if (bus.burst_beats !== 16'd4) $display("FAIL bp_count: got %0d want 4", bus.burst_beats); else n_pass++;
      tick;
   endtask

   task automatic test_timeout;
      bus.slv1_data_valid = 1'b1; bus.slv1_mode = 2'd1;
      tick;
      n_total++; if (bus.data_source !== 1'b1) $display("FAIL to_src: got %0h want 1", bus.data_source); else n_pass++;
      bus.slv1_data_valid = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         #1;
         n_total++; if (bus.burst_timeout !== (j == 8)) $display("FAIL to_pulse%0d: got %0h want %0h", j, bus.burst_timeout, (j == 8)); else n_pass++;
         tick;
      end
      n_total++; if ({bus.burst_timeout, bus.slv1_ready} !== 2'b00) $display("FAIL to_release: got %b want 00", {bus.burst_timeout, bus.slv1_ready}); else n_pass++;
      tick;
      bus.slv0_data_valid = 1'b1; bus.slv1_data_valid = 1'b1;
      tick;
      n_total++; if (bus.data_source !== 1'b0) $display("FAIL to_next_src: got %0h want 0", bus.data_source); else n_pass++;
      bus.slv0_data_valid = 1'b0; bus.slv1_data_valid = 1'b0; bus.mstr0_cmplt = 1'b1;
      tick;
      bus.mstr0_cmplt = 1'b0;
      tick;
   endtask

   task automatic test_cmplt_beat;
      bus.slv1_data_valid = 1'b1; bus.slv1_data = 32'hAA;
      tick;
      bus.mstr0_cmplt = 1'b1;
      tick;
      bus.mstr0_cmplt = 1'b0; bus.slv1_data_valid = 1'b0;
      n_total++; if (bus.slvx_data_valid !== 1'b1 || bus.slvx_data !== 32'hAA) $display("FAIL cb_beat: got %0h/%0h want 1/aa", bus.slvx_data_valid, bus.slvx_data); else n_pass++;
      n_total++; if (bus.burst_beats !== 16'd1 || bus.slv1_ready !== 1'b0) $display("FAIL cb_release: got %0d/%0h want 1/0", bus.burst_beats, bus.slv1_ready); else n_pass++;
      tick;
      // cmplt while IDLE must not disturb the next grant
      bus.mstr0_cmplt = 1'b1; bus.slv0_data_valid = 1'b1; bus.slv0_data = 32'hBB;
      tick;
      bus.mstr0_cmplt = 1'b0;
      #1;
      n_total++; if (bus.slv0_ready !== 1'b1 || bus.data_source !== 1'b0) $display("FAIL cb_idle_cmplt: got %0h/%0h want 1/0", bus.slv0_ready, bus.data_source); else n_pass++;
      bus.mstr0_cmplt = 1'b1;
      tick;
      bus.mstr0_cmplt = 1'b0; bus.slv0_data_valid = 1'b0;
      n_total++; if (bus.slvx_data !== 32'hBB) $display("FAIL cb_bb: got %0h want bb", bus.slvx_data); else n_pass++;
      tick;
   endtask

   task automatic test_reset_mid;
      bus.slv0_data_valid = 1'b1; bus.slv0_data = 32'h51; bus.slv0_mode = 2'd3;
      tick;
      tick;
      n_total++; if (bus.slvx_data !== 32'h51) $display("FAIL rm_beat1: got %0h want 51", bus.slvx_data); else n_pass++;
      bus.slv0_data = 32'h52; rst = 1'b1;
      tick;
      rst = 1'b0;
      n_total++; if (bus.slvx_data_valid !== 1'b0 || bus.slvx_data !== 32'h0 || bus.burst_beats !== 16'h0)
         $display("FAIL rm_zero: got %0h/%0h/%0h want 0/0/0", bus.slvx_data_valid, bus.slvx_data, bus.burst_beats); else n_pass++;
      n_total++; if (bus.slvx_mode !== 2'd0 || bus.slv0_ready !== 1'b0) $display("FAIL rm_ctrl: got %0h/%0h want 0/0", bus.slvx_mode, bus.slv0_ready); else n_pass++;
      bus.slv1_data_valid = 1'b1;
      tick;
      n_total++; if (bus.data_source !== 1'b0 || bus.slv0_ready !== 1'b1) $display("FAIL rm_regrant: got %0h/%0h want 0/1", bus.data_source, bus.slv0_ready); else n_pass++;
      bus.slv0_data_valid = 1'b0; bus.slv1_data_valid = 1'b0; bus.mstr0_cmplt = 1'b1;
      tick;
      bus.mstr0_cmplt = 1'b0;
      tick;
   endtask

   initial begin
      bus.slv0_mode = '0; bus.slv0_data_valid = 1'b0; bus.slv0_proc_valid = '0; bus.slv0_data = '0;
      bus.slv1_mode = '0; bus.slv1_data_valid = 1'b0; bus.slv1_proc_valid = '0; bus.slv1_data = '0;
      bus.mstr0_cmplt = 1'b0; bus.fifo_full = 1'b0;
      test_reset;
      test_contention;
      test_single;
      test_backpressure;
      test_timeout;
      test_cmplt_beat;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
